// File: rtl/mac_stage.sv
// Four-lane multiply-accumulate stage feeding the RAM write-back stage.
// Sums N_TERMS sample*coef products per lane, then strobes web and holds MU1..MU4.
module mac_stage #(
    parameter int unsigned DW      = 8,
    parameter int unsigned CW      = 7,
    parameter int unsigned AW      = 18,
    parameter int unsigned N_TERMS = 8,
    parameter int unsigned HOLD    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] data_in,
    input  logic [4*CW-1:0] coef,
    output logic [2:0]    term_idx,
    output logic          busy,
    output logic          web,
    output logic [AW-1:0] MU1,
    output logic [AW-1:0] MU2,
    output logic [AW-1:0] MU3,
    output logic [AW-1:0] MU4
);

    localparam int unsigned CntW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {StIdle, StAcc, StDone, StCool} state_e;

    state_e          state_q, state_d;
    logic [2:0]      term_q, term_d;
    logic [CntW-1:0] cool_q, cool_d;
    logic [AW-1:0]   acc_q [4];
    logic [AW-1:0]   acc_d [4];
    logic [AW-1:0]   mu_q  [4];
    logic [AW-1:0]   mu_d  [4];
    logic [AW-1:0]   sum   [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sum[i]   = acc_q[i] + AW'(data_in) * AW'(coef[i*CW +: CW]);
            acc_d[i] = acc_q[i];
            mu_d[i]  = mu_q[i];
        end
        state_d = state_q;
        term_d  = term_q;
        cool_d  = cool_q;

        unique case (state_q)
            StIdle: begin
                // start wins over a coincident in_valid; no beat taken here
                if (start) begin
                    state_d = StAcc;
                    term_d  = '0;
                    for (int i = 0; i < 4; i++) acc_d[i] = '0;
                end
            end
            StAcc: begin
                if (in_valid) begin
                    if (term_q == 3'(N_TERMS - 1)) begin
                        for (int i = 0; i < 4; i++) mu_d[i] = sum[i];
                        term_d  = '0;
                        state_d = StDone;
                    end else begin
                        for (int i = 0; i < 4; i++) acc_d[i] = sum[i];
                        term_d = term_q + 3'd1;
                    end
                end
            end
            StDone: begin
                cool_d  = '0;
                state_d = StCool;
            end
            StCool: begin
                if (cool_q == CntW'(HOLD - 1)) begin
                    state_d = StIdle;
                end else begin
                    cool_d = cool_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            term_q  <= '0;
            cool_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
                mu_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            cool_q  <= cool_d;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= acc_d[i];
                mu_q[i]  <= mu_d[i];
            end
        end
    end

    assign term_idx = term_q;
    assign busy     = (state_q != StIdle);
    assign web      = (state_q == StDone);
    assign MU1      = mu_q[0];
    assign MU2      = mu_q[1];
    assign MU3      = mu_q[2];
    assign MU4      = mu_q[3];

endmodule

// File: tb/tb_mac_stage.sv
// Directed bench for mac_stage: hand-computed sums, strobe timing, start filtering,
// mid-run reset and back-to-back spacing.
module tb_mac_stage;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 7;
    localparam int unsigned AW = 18;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] data_in;
    logic [4*CW-1:0] coef;
    logic [2:0]    term_idx;
    logic          busy;
    logic          web;
    logic [AW-1:0] MU1, MU2, MU3, MU4;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int web_a, web_b;

    mac_stage dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .data_in  (data_in),
        .coef     (coef),
        .term_idx (term_idx),
        .busy     (busy),
        .web      (web),
        .MU1      (MU1),
        .MU2      (MU2),
        .MU3      (MU3),
        .MU4      (MU4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [4*CW-1:0] pack(input int l1, input int l2, input int l3,
                                             input int l4);
        return {CW'(l4), CW'(l3), CW'(l2), CW'(l1)};
    endfunction

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic beat(input int d, input logic [4*CW-1:0] c);
        data_in  = DW'(d);
        coef     = c;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_mu(input string tag, input int e1, input int e2, input int e3,
                          input int e4);
        chk({tag, ".mu1"}, 32'(MU1), e1);
        chk({tag, ".mu2"}, 32'(MU2), e2);
        chk({tag, ".mu3"}, 32'(MU3), e3);
        chk({tag, ".mu4"}, 32'(MU4), e4);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        coef     = '0;
        step();
        step();

        // T1 reset state and basic run
        chk("t1.rst.term", 32'(term_idx), 0);
        chk("t1.rst.busy", 32'(busy), 0);
        chk("t1.rst.web", 32'(web), 0);
        chk_mu("t1.rst", 0, 0, 0, 0);
        rst = 1'b1;
        step();
        do_start();
        chk("t1.busy", 32'(busy), 1);
        for (int i = 0; i < 7; i++) beat(1, pack(1, 2, 3, 4));
        chk("t1.term7", 32'(term_idx), 7);
        chk("t1.web_early", 32'(web), 0);
        beat(1, pack(1, 2, 3, 4));
        chk("t1.web", 32'(web), 1);
        chk("t1.term_wrap", 32'(term_idx), 0);
        chk_mu("t1", 8, 16, 24, 32);
        step();
        chk("t1.web_off", 32'(web), 0);
        chk("t1.cool_busy", 32'(busy), 1);
        step();
        step();
        chk("t1.cool_busy3", 32'(busy), 1);
        step();
        chk("t1.idle", 32'(busy), 0);

        // T2 maximum operands, no wrap
        do_start();
        for (int i = 0; i < 8; i++) beat(255, pack(127, 127, 127, 127));
        chk("t2.web", 32'(web), 1);
        chk_mu("t2", 259080, 259080, 259080, 259080);
        for (int i = 0; i < 4; i++) step();

        // T3 stalls between beats; data 1..8, lanes 1,2,10,127
        do_start();
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < i % 4; g++) begin
                step();
                chk("t3.stall_term", 32'(term_idx), i);
            end
            chk("t3.no_web", 32'(web), 0);
            beat(i + 1, pack(1, 2, 10, 127));
        end
        chk("t3.web", 32'(web), 1);
        chk_mu("t3", 36, 72, 360, 4572);
        step();
        chk("t3.web_1cyc", 32'(web), 0);
        for (int i = 0; i < 3; i++) step();

        // T4 start+in_valid in IDLE; start in ACC and COOL ignored
        start    = 1'b1;
        in_valid = 1'b1;
        data_in  = 8'd100;
        coef     = pack(100, 100, 100, 100);
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("t4.beat_ignored", 32'(term_idx), 0);
        chk("t4.busy", 32'(busy), 1);
        for (int i = 0; i < 3; i++) beat(2, pack(1, 2, 3, 4));
        start = 1'b1;
        step();
        chk("t4.acc_start_term", 32'(term_idx), 3);
        beat(2, pack(1, 2, 3, 4));
        start = 1'b0;
        chk("t4.acc_start_beat", 32'(term_idx), 4);
        for (int i = 0; i < 4; i++) beat(2, pack(1, 2, 3, 4));
        chk("t4.web", 32'(web), 1);
        chk_mu("t4", 16, 32, 48, 64);
        step();
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_mu("t4.hold", 16, 32, 48, 64);
            chk("t4.hold_web", 32'(web), 0);
            step();
        end
        start = 1'b0;
        chk("t4.cool_start_ignored", 32'(busy), 0);
        chk_mu("t4.held_idle", 16, 32, 48, 64);

        // T5 reset after 5 beats
        do_start();
        for (int i = 0; i < 5; i++) beat(9, pack(9, 9, 9, 9));
        chk("t5.term5", 32'(term_idx), 5);
        #2;
        rst = 1'b0;
        #1;
        chk("t5.term", 32'(term_idx), 0);
        chk("t5.busy", 32'(busy), 0);
        chk_mu("t5.rst", 0, 0, 0, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5.no_web", 32'(web), 0);
        end
        do_start();
        for (int i = 0; i < 8; i++) beat(3, pack(5, 6, 7, 8));
        chk("t5.web", 32'(web), 1);
        chk_mu("t5", 120, 144, 168, 192);
        for (int i = 0; i < 4; i++) step();

        // T6 back-to-back runs at minimum spacing
        do_start();
        for (int i = 0; i < 8; i++) beat(i, pack(1, 2, 3, 4));
        chk("t6a.web", 32'(web), 1);
        web_a = cyc;
        chk_mu("t6a", 28, 56, 84, 112);
        for (int i = 0; i < 4; i++) step();
        do_start();
        chk("t6b.accepted", 32'(busy), 1);
        for (int i = 0; i < 8; i++) beat(200, pack(127, 0, 1, 64));
        chk("t6b.web", 32'(web), 1);
        web_b = cyc;
        chk_mu("t6b", 203200, 0, 1600, 102400);
        chk("t6.spacing", 32'(web_b - web_a), 13);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
